// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Converts a 13-bit binary value to four BCD digits with a sequential
//   double-dabble engine, then time-multiplexes the digits onto a 4-digit
//   common-anode seven-segment display.
//
//   Optional build macro: SSD_LEADING_BLANK_EN
//     defined   -> leading zero digits are blanked (ones digit always shown)
//     undefined -> all four numerals are always shown
//
// Ports
//   clk      in   display clock, rising edge
//   rst      in   synchronous active-high reset
//   num      in   13-bit unsigned value to convert
//   load     in   capture num and start a conversion (honoured only when idle)
//   busy     out  conversion in progress
//   bcd      out  displayed value, {thousands, hundreds, tens, ones}
//   anode    out  digit enables, active-low, anode[0] = ones digit
//   cathode  out  segments {g,f,e,d,c,b,a}, active-low
//
// state  | meaning
// IDLE   | waiting for load; display register stable
// CONV   | 13 add-3/shift iterations of double-dabble
// DONE   | copy scratch into the display register, return to IDLE

module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  input  logic        load,
  output logic        busy,
  output logic [15:0] bcd,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int             CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [3:0]     LAST_IT  = 4'd12;

  logic [1:0]    state_q,   state_d;
  logic [12:0]   shift_q,   shift_d;
  logic [15:0]   scratch_q, scratch_d;
  logic [3:0]    iter_q,    iter_d;
  logic [15:0]   bcd_q,     bcd_d;
  logic [CW-1:0] rcnt_q,    rcnt_d;
  logic [1:0]    idx_q,     idx_d;

  logic [14:0]   adj;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // The thousands nibble never reaches 5 before a shift (a 13-bit input
  // tops out at 8191), so it needs no add-3 and its MSB is always 0 when
  // shifted out. Only the 15 bits that survive the shift are formed.
  always_comb begin
    adj = {scratch_q[14:12], add3(scratch_q[11:8]),
           add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = num;
          scratch_d = 16'h0000;
          iter_d    = 4'd0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        scratch_d = {adj, shift_q[12]};
        shift_d   = {shift_q[11:0], 1'b0};
        iter_d    = iter_q + 4'd1;
        if (iter_q == LAST_IT) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = scratch_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q + CW'(1);
    idx_d  = idx_q;
    if (rcnt_q == CNT_MAX) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    digit = bcd_q[3:0];
      2'd1:    digit = bcd_q[7:4];
      2'd2:    digit = bcd_q[11:8];
      default: digit = bcd_q[15:12];
    endcase
`ifdef SSD_LEADING_BLANK_EN
    // A digit blanks when it and everything to its left is zero.
    case (idx_q)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8]  == 8'd0);
      2'd1:    blank = (bcd_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      rcnt_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      rcnt_q    <= rcnt_d;
      idx_q     <= idx_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign bcd     = bcd_q;
  assign anode   = ~(4'b0001 << idx_q);
  assign cathode = blank ? 7'b1111111 : seg7(digit);

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] num;
  logic        load;
  logic        busy;
  logic [15:0] bcd;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .load    (load),
    .busy    (busy),
    .bcd     (bcd),
    .anode   (anode),
    .cathode (cathode)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse load for one edge, then count the cycles busy stays high.
  task automatic convert(input logic [12:0] v, output int busy_cycles, output logic [15:0] mid_bcd);
    @(negedge clk);
    num  = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    mid_bcd = bcd;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic seg_at(input string tag, input logic [3:0] an, input logic [6:0] exp);
    int n = 0;
    while (anode !== an && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_anode_reached"}, {12'd0, anode}, {12'd0, an});
    check(tag, {9'd0, cathode}, {9'd0, exp});
  endtask

  initial begin
    int          bc;
    logic [15:0] mid;

    rst  = 1'b1;
    load = 1'b0;
    num  = '0;

    // 1: reset values and scan sequence
    repeat (2) @(negedge clk);
    check("rst_busy",    {15'd0, busy},   16'd0);
    check("rst_bcd",     bcd,             16'h0000);
    check("rst_anode",   {12'd0, anode},  16'h000E);
    check("rst_cathode", {9'd0, cathode}, {9'd0, 7'b1000000});
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("scan_r3", {12'd0, anode}, {12'd0, 4'b1110});
    @(negedge clk);
    check("scan_r4", {12'd0, anode}, {12'd0, 4'b1101});
    repeat (4) @(negedge clk);
    check("scan_r8", {12'd0, anode}, {12'd0, 4'b1011});
    repeat (4) @(negedge clk);
    check("scan_r12", {12'd0, anode}, {12'd0, 4'b0111});
    repeat (4) @(negedge clk);
    check("scan_r16", {12'd0, anode}, {12'd0, 4'b1110});

    // 2: 1234, busy length and per-digit segments
    convert(13'd1234, bc, mid);
    check("c1234_busy_len", 16'(bc), 16'd14);
    check("c1234_old_bcd",  mid,     16'h0000);
    check("c1234_bcd",      bcd,     16'h1234);
    seg_at("c1234_seg0", 4'b1110, 7'b0011001);
    seg_at("c1234_seg1", 4'b1101, 7'b0110000);
    seg_at("c1234_seg2", 4'b1011, 7'b0100100);
    seg_at("c1234_seg3", 4'b0111, 7'b1111001);

    // 3: extremes; old value held while converting
    convert(13'd8191, bc, mid);
    check("c8191_bcd", bcd, 16'h8191);
    convert(13'd0, bc, mid);
    check("c0_old_bcd", mid, 16'h8191);
    check("c0_bcd",     bcd, 16'h0000);

    // 4: load during conversion is dropped
    @(negedge clk);
    num  = 13'd5678;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    num  = 13'd42;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("drop_busy_e3", {15'd0, busy}, 16'd1);
    repeat (11) @(negedge clk);
    check("drop_busy_e14", {15'd0, busy}, 16'd0);
    check("drop_bcd",      bcd,           16'h5678);

    // 5: single-digit value, leading digits
    convert(13'd7, bc, mid);
    check("c7_bcd", bcd, 16'h0007);
    seg_at("c7_seg0", 4'b1110, 7'b1111000);
`ifdef SSD_LEADING_BLANK_EN
    seg_at("c7_seg1", 4'b1101, 7'b1111111);
    seg_at("c7_seg2", 4'b1011, 7'b1111111);
    seg_at("c7_seg3", 4'b0111, 7'b1111111);
`else
    seg_at("c7_seg1", 4'b1101, 7'b1000000);
    seg_at("c7_seg2", 4'b1011, 7'b1000000);
    seg_at("c7_seg3", 4'b0111, 7'b1000000);
`endif

    // load held high: back-to-back conversions
    @(negedge clk);
    num  = 13'd3;
    load = 1'b1;
    repeat (15) @(negedge clk);
    check("hold_busy_e14", {15'd0, busy}, 16'd0);
    check("hold_bcd",      bcd,           16'h0003);
    @(negedge clk);
    check("hold_busy_e15", {15'd0, busy}, 16'd1);
    load = 1'b0;
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    check("hold_busy_len", 16'(bc), 16'd14);

    // 6: reset aborts a conversion
    @(negedge clk);
    num  = 13'd999;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",    {15'd0, busy},   16'd0);
    check("abort_bcd",     bcd,             16'h0000);
    check("abort_anode",   {12'd0, anode},  16'h000E);
    check("abort_cathode", {9'd0, cathode}, {9'd0, 7'b1000000});
    convert(13'd999, bc, mid);
    check("c999_busy_len", 16'(bc), 16'd14);
    check("c999_bcd",      bcd,     16'h0999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
